// File: rtl/execute_md.sv
// RV32IM execute stage: ALU, branch/jump resolution, EX/MEM registers and an
// iterative multiply/divide unit that stalls the control unit through busy.
// Optional build macro EXE_FAST_MUL_EN: MUL/MULH/MULHSU/MULHU use a combinational
// multiplier and never raise busy; DIV/DIVU/REM/REMU stay iterative.
module execute_md #(
  parameter int unsigned N     = 32,
  parameter int unsigned CNT_W = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         regEn,
  input  logic         flush,
  input  logic [N-1:0] NPCin,
  input  logic [N-1:0] NPC4_IN,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [N-1:0] Imm,
  input  logic         muxSel,
  input  logic [3:0]   aluControl,
  input  logic         mdValid,
  input  logic [2:0]   mdOp,
  input  logic [2:0]   branch,
  input  logic         jmp_en,
  output logic [N-1:0] jPC,
  output logic         PC_sel,
  output logic         busy,
  output logic [N-1:0] ALUres,
  output logic [N-1:0] Bout,
  output logic [N-1:0] ImmOUT,
  output logic [N-1:0] NPC4_OUT
);

  localparam int unsigned ShW = $clog2(N);

  localparam logic [3:0] AluAdd   = 4'd0;
  localparam logic [3:0] AluSub   = 4'd1;
  localparam logic [3:0] AluAnd   = 4'd2;
  localparam logic [3:0] AluOr    = 4'd3;
  localparam logic [3:0] AluXor   = 4'd4;
  localparam logic [3:0] AluSll   = 4'd5;
  localparam logic [3:0] AluSrl   = 4'd6;
  localparam logic [3:0] AluSra   = 4'd7;
  localparam logic [3:0] AluSlt   = 4'd8;
  localparam logic [3:0] AluSltu  = 4'd9;
  localparam logic [3:0] AluPassB = 4'd10;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} md_state_e;

  md_state_e state_q, state_d;

  logic [N-1:0]   op_b;
  logic [N-1:0]   alu_res;
  logic [ShW-1:0] shamt;
  logic           taken;

  // MD unit state: acc holds {hi, lo} for both shift-add and restoring divide
  logic [2*N:0]     acc_q, acc_step;
  logic [N-1:0]     opb_q;
  logic [2:0]       op_q;
  logic             sa_q, sb_q, bz_q;
  logic [CNT_W-1:0] cnt_q;

  logic           a_signed, b_signed, a_neg, b_neg;
  logic [N-1:0]   a_mag, b_mag;
  logic           md_iter, fast_sel, start, load;
  logic [N-1:0]   fast_res, md_res;
  logic [N:0]     mul_sum, div_tr;
  logic           div_ge;
  logic [2*N-1:0] prod, prod_s;
  logic [N-1:0]   quo, rem;

  assign op_b  = muxSel ? Imm : B;
  assign shamt = op_b[ShW-1:0];

  // ALU result for the single-cycle path
  always_comb begin
    alu_res = '0;
    case (aluControl)
      AluAdd:   alu_res = A + op_b;
      AluSub:   alu_res = A - op_b;
      AluAnd:   alu_res = A & op_b;
      AluOr:    alu_res = A | op_b;
      AluXor:   alu_res = A ^ op_b;
      AluSll:   alu_res = A << shamt;
      AluSrl:   alu_res = A >> shamt;
      AluSra:   alu_res = $unsigned($signed(A) >>> shamt);
      AluSlt:   alu_res = {{(N-1){1'b0}}, $signed(A) < $signed(op_b)};
      AluSltu:  alu_res = {{(N-1){1'b0}}, A < op_b};
      AluPassB: alu_res = op_b;
      default:  alu_res = '0;
    endcase
  end

  // Branch resolution on raw rs1/rs2; independent of the MD unit
  always_comb begin
    taken = 1'b0;
    case (branch)
      3'd1:    taken = (A == B);
      3'd2:    taken = (A != B);
      3'd3:    taken = ($signed(A) < $signed(B));
      3'd4:    taken = ($signed(A) >= $signed(B));
      3'd5:    taken = (A < B);
      3'd6:    taken = (A >= B);
      default: taken = 1'b0;
    endcase
  end

  assign PC_sel = jmp_en | taken;
  assign jPC    = NPCin + (Imm << 1);

  // Operand signedness: MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM rs2
  assign a_signed = (mdOp == 3'd1) | (mdOp == 3'd2) | (mdOp == 3'd4) | (mdOp == 3'd6);
  assign b_signed = (mdOp == 3'd1) | (mdOp == 3'd4) | (mdOp == 3'd6);
  assign a_neg    = a_signed & A[N-1];
  assign b_neg    = b_signed & B[N-1];
  assign a_mag    = a_neg ? -A : A;
  assign b_mag    = b_neg ? -B : B;

`ifdef EXE_FAST_MUL_EN
  logic [2*N-1:0] fm_a, fm_b, fm_p;
  // Sign-extending to 2N bits makes one unsigned multiply serve all MUL variants
  assign fm_a     = {{N{a_neg}}, A};
  assign fm_b     = {{N{b_neg}}, B};
  assign fm_p     = fm_a * fm_b;
  assign md_iter  = mdOp[2];
  assign fast_sel = mdValid & ~mdOp[2];
  assign fast_res = (mdOp == 3'd0) ? fm_p[N-1:0] : fm_p[2*N-1:N];
`else
  assign md_iter  = 1'b1;
  assign fast_sel = 1'b0;
  assign fast_res = '0;
`endif

  assign start = (state_q == StIdle) & mdValid & md_iter & ~flush;
  assign load  = regEn & ~busy;

  // One shift-add or restoring-subtract step of the MD unit
  always_comb begin
    mul_sum  = acc_q[2*N:N] + (acc_q[0] ? {1'b0, opb_q} : '0);
    div_tr   = acc_q[2*N-1:N-1];
    div_ge   = (div_tr >= {1'b0, opb_q});
    acc_step = acc_q;
    if (op_q[2]) begin
      if (div_ge) acc_step = {div_tr - {1'b0, opb_q}, acc_q[N-2:0], 1'b1};
      else        acc_step = {div_tr, acc_q[N-2:0], 1'b0};
    end else begin
      acc_step = {1'b0, mul_sum, acc_q[N-1:1]};
    end
  end

  // Sign fix-up and result select; MUL latches no signs so prod_s is the raw product
  always_comb begin
    prod   = acc_q[2*N-1:0];
    prod_s = (sa_q ^ sb_q) ? -prod : prod;
    quo    = acc_q[N-1:0];
    rem    = acc_q[2*N-1:N];
    md_res = '0;
    case (op_q)
      3'd0:             md_res = prod_s[N-1:0];
      3'd1, 3'd2, 3'd3: md_res = prod_s[2*N-1:N];
      3'd4:             md_res = ((sa_q ^ sb_q) & ~bz_q) ? -quo : quo;
      3'd5:             md_res = quo;
      3'd6:             md_res = sa_q ? -rem : rem;
      default:          md_res = rem;
    endcase
  end

  // MD operand latch and iteration datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      opb_q <= '0;
      op_q  <= '0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      bz_q  <= 1'b0;
      cnt_q <= '0;
    end else if (start) begin
      acc_q <= {{(N+1){1'b0}}, a_mag};
      opb_q <= b_mag;
      op_q  <= mdOp;
      sa_q  <= a_neg;
      sb_q  <= b_neg;
      bz_q  <= (B == '0);
      cnt_q <= '0;
    end else if (state_q == StCalc) begin
      acc_q <= acc_step;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // MD FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // MD FSM next state and stall request
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy = mdValid & md_iter;
        if (mdValid & md_iter) state_d = StCalc;
      end
      StCalc: begin
        busy = 1'b1;
        if (cnt_q == CNT_W'(N - 1)) state_d = StDone;
      end
      StDone: begin
        if (regEn) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
    if (rst)   busy    = 1'b0;
  end

  // EX/MEM pipeline registers
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ALUres   <= '0;
      Bout     <= '0;
      ImmOUT   <= '0;
      NPC4_OUT <= '0;
    end else if (load) begin
      if (state_q == StDone) ALUres <= md_res;
      else if (fast_sel)     ALUres <= fast_res;
      else                   ALUres <= alu_res;
      Bout     <= B;
      ImmOUT   <= Imm;
      NPC4_OUT <= NPC4_IN;
    end
  end

endmodule

// File: tb/tb_execute_md.sv
// Directed bench for execute_md: reset, ALU, branches, M-extension ops and
// their corner cases, DONE stall and CALC flush. ALUres expectations go through
// a scoreboard queue pushed at issue and popped when the EX/MEM load happens.
module tb_execute_md;
  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         rst, regEn, flush, muxSel, mdValid, jmp_en;
  logic [N-1:0] NPCin, NPC4_IN, A, B, Imm;
  logic [3:0]   aluControl;
  logic [2:0]   mdOp, branch;
  logic [N-1:0] jPC, ALUres, Bout, ImmOUT, NPC4_OUT;
  logic         PC_sel, busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string        tag;
    logic [N-1:0] val;
  } exp_t;

  exp_t         sb_q[$];
  logic [N-1:0] last_exp = '0;

  always #5 clk = ~clk;

  execute_md #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .regEn      (regEn),
    .flush      (flush),
    .NPCin      (NPCin),
    .NPC4_IN    (NPC4_IN),
    .A          (A),
    .B          (B),
    .Imm        (Imm),
    .muxSel     (muxSel),
    .aluControl (aluControl),
    .mdValid    (mdValid),
    .mdOp       (mdOp),
    .branch     (branch),
    .jmp_en     (jmp_en),
    .jPC        (jPC),
    .PC_sel     (PC_sel),
    .busy       (busy),
    .ALUres     (ALUres),
    .Bout       (Bout),
    .ImmOUT     (ImmOUT),
    .NPC4_OUT   (NPC4_OUT)
  );

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [N-1:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty observed=0 entries expected=1 entry");
    end else begin
      e = sb_q.pop_front();
      check(e.tag, ALUres, e.val);
      last_exp = e.val;
    end
  endtask

  task automatic quiet_inputs();
    regEn = 1'b0; flush = 1'b0; muxSel = 1'b0; mdValid = 1'b0; jmp_en = 1'b0;
    NPCin = '0; NPC4_IN = '0; A = '0; B = '0; Imm = '0;
    aluControl = 4'd0; mdOp = 3'd0; branch = 3'd0;
  endtask

  // Issue one M op, count busy cycles, optionally stall in DONE, then check the load
  task automatic run_md(input string tag, input logic [2:0] op, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic [N-1:0] res, input int stall);
    int cyc;
    int exp_busy;
    A = a; B = b; mdOp = op; mdValid = 1'b1; muxSel = 1'b0;
    branch = 3'd0; jmp_en = 1'b0;
    regEn = (stall == 0);
    push_exp(tag, res);
    exp_busy = N + 1;
`ifdef EXE_FAST_MUL_EN
    if (!op[2]) exp_busy = 0;
`endif
    #1;
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      step();
    end
    check({tag, "_busy_cycles"}, N'(cyc), N'(exp_busy));
    for (int i = 0; i < stall; i++) begin
      step();
      check({tag, "_held"}, ALUres, last_exp);
      check({tag, "_busy_in_done"}, N'(busy), N'(0));
    end
    regEn = 1'b1;
    step();
    mdValid = 1'b0;
    pop_check();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    quiet_inputs();
    // Reset held 2 cycles with random inputs
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      A = $urandom; B = $urandom; Imm = $urandom; NPCin = $urandom; NPC4_IN = $urandom;
      regEn = 1'($urandom); mdValid = 1'($urandom); mdOp = 3'($urandom);
      aluControl = 4'($urandom); muxSel = 1'($urandom); flush = 1'($urandom);
      #1;
      check("reset_busy", N'(busy), N'(0));
      step();
    end
    check("reset_alures", ALUres, '0);
    check("reset_bout", Bout, '0);
    check("reset_immout", ImmOUT, '0);
    check("reset_npc4", NPC4_OUT, '0);
    check("reset_busy_end", N'(busy), N'(0));
    quiet_inputs();
    rst = 1'b0;
    step();

    // ALU add 5 + 7
    A = 32'd5; B = 32'd7; Imm = 32'h55; NPC4_IN = 32'h104; aluControl = 4'd0; regEn = 1'b1;
    push_exp("alu_add", 32'd12);
    #1;
    check("alu_add_busy", N'(busy), N'(0));
    step();
    pop_check();
    check("alu_add_bout", Bout, 32'd7);
    check("alu_add_immout", ImmOUT, 32'h55);
    check("alu_add_npc4", NPC4_OUT, 32'h104);

    // ALU sub with immediate operand
    A = 32'd20; Imm = 32'd3; muxSel = 1'b1; aluControl = 4'd1;
    push_exp("alu_sub_imm", 32'd17);
    step();
    pop_check();

    // regEn low holds EX/MEM
    A = 32'd99; muxSel = 1'b0; aluControl = 4'd0; regEn = 1'b0;
    push_exp("alu_hold", 32'd17);
    step();
    pop_check();

    // Branch / jump resolution
    A = 32'd3; B = 32'd3; branch = 3'd1; NPCin = 32'h100; Imm = 32'd8;
    #1;
    check("beq_pcsel", N'(PC_sel), N'(1));
    check("beq_jpc", jPC, 32'h110);
    branch = 3'd2; #1;
    check("bne_equal_pcsel", N'(PC_sel), N'(0));
    branch = 3'd7; #1;
    check("br7_pcsel", N'(PC_sel), N'(0));
    A = 32'hFFFF_FFFF; B = 32'd1; branch = 3'd5; #1;
    check("bltu_pcsel", N'(PC_sel), N'(0));
    branch = 3'd3; #1;
    check("blt_pcsel", N'(PC_sel), N'(1));
    branch = 3'd0; jmp_en = 1'b1; #1;
    check("jmp_pcsel", N'(PC_sel), N'(1));
    jmp_en = 1'b0;
    step();

    // Multiply variants
    run_md("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
    run_md("mul",    3'd0, 32'd3,         32'hFFFF_FFFC, 32'hFFFF_FFF4, 0);
    run_md("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_md("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

    // Divide corner cases
    run_md("div_by0", 3'd4, 32'd7,         32'd0,         32'hFFFF_FFFF, 0);
    run_md("rem_by0", 3'd6, 32'd7,         32'd0,         32'd7,         0);
    run_md("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_md("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0);
    run_md("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0);
    run_md("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0);
    run_md("remu",    3'd7, 32'd100,       32'd7,         32'd2,         0);

    // DIVU held in DONE by regEn=0 for 3 cycles
    run_md("divu_stall", 3'd5, 32'd100, 32'd7, 32'd14, 3);

    // Flush at CALC cycle 10
    A = 32'd1000; B = 32'd3; mdOp = 3'd4; mdValid = 1'b1; regEn = 1'b1;
    #1;
    check("flush_busy_start", N'(busy), N'(1));
    step();
    for (int i = 0; i < 10; i++) step();
    check("flush_busy_calc", N'(busy), N'(1));
    flush = 1'b1; mdValid = 1'b0;
    step();
    flush = 1'b0;
    check("flush_busy", N'(busy), N'(0));
    check("flush_alures", ALUres, '0);
    check("flush_bout", Bout, '0);

    // Plain ALU op after flush
    A = 32'd1; B = 32'd2; aluControl = 4'd0; regEn = 1'b1;
    push_exp("alu_after_flush", 32'd3);
    step();
    pop_check();

    check("scoreboard_drained", N'(sb_q.size()), N'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
